// File: rtl/dma_dscrptr_dispatch_rsp.sv
// dma_dscrptr_dispatch_rsp: accepts one descriptor dispatch, hands it to the transfer engine,
// watches it with a watchdog and returns a done pulse plus a completion record.
module dma_dscrptr_dispatch_rsp #(
  parameter int NUM_INT_BDS       = 4,
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int DSCRPTR_WIDTH     = 133,
  parameter int TIMEOUT           = 1024
) (
  input  logic                         clock_i,
  input  logic                         resetn_i,
  input  logic                         dispatch_valid_i,
  input  logic [NUM_INT_BDS_WIDTH-1:0] dispatch_num_i,
  input  logic                         dispatch_ext_i,
  input  logic                         dispatch_str_i,
  input  logic [31:0]                  dispatch_addr_i,
  input  logic [DSCRPTR_WIDTH-1:0]     dispatch_dscrptr_i,
  output logic                         dispatch_done_o,
  output logic                         xfer_req_o,
  output logic [NUM_INT_BDS_WIDTH-1:0] xfer_num_o,
  output logic                         xfer_ext_o,
  output logic                         xfer_str_o,
  output logic [31:0]                  xfer_addr_o,
  output logic [DSCRPTR_WIDTH-1:0]     xfer_dscrptr_o,
  input  logic                         xfer_ack_i,
  input  logic                         xfer_done_i,
  input  logic                         xfer_err_i,
  output logic                         xfer_abort_o,
  output logic                         cmplt_valid_o,
  output logic [NUM_INT_BDS_WIDTH-1:0] cmplt_num_o,
  output logic                         cmplt_err_o,
  output logic                         cmplt_timeout_o,
  output logic                         protocol_err_o,
  input  logic                         err_clr_i
);
  typedef enum logic [1:0] {IDLE, REQ, BUSY, CMPLT} state_e;
  if (TIMEOUT < 0 || TIMEOUT > 65535 || NUM_INT_BDS > (1 << NUM_INT_BDS_WIDTH)) begin : g_param_chk
    $error("dma_dscrptr_dispatch_rsp: parameter out of range");
  end
  state_e                         state_q;
  logic [15:0]                    cnt_q;
  logic [NUM_INT_BDS_WIDTH-1:0]   num_q, cmplt_num_q;
  logic                           ext_q, str_q, cmplt_err_q, cmplt_to_q, protocol_err_q;
  logic [31:0]                    addr_q;
  logic [DSCRPTR_WIDTH-1:0]       dsc_q;
  logic                           expire;
  // Done in the expiry cycle wins, so the abort is qualified by the live done input.
  assign expire          = (TIMEOUT != 0) && (cnt_q == 16'(TIMEOUT - 1));
  assign xfer_req_o      = state_q == REQ;
  assign dispatch_done_o = state_q == CMPLT;
  assign cmplt_valid_o   = state_q == CMPLT;
  assign xfer_abort_o    = state_q == BUSY && expire && !xfer_done_i;
  assign xfer_num_o      = num_q;
  assign xfer_ext_o      = ext_q;
  assign xfer_str_o      = str_q;
  assign xfer_addr_o     = addr_q;
  assign xfer_dscrptr_o  = dsc_q;
  assign cmplt_num_o     = cmplt_num_q;
  assign cmplt_err_o     = cmplt_err_q;
  assign cmplt_timeout_o = cmplt_to_q;
  assign protocol_err_o  = protocol_err_q;
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      num_q          <= '0;
      ext_q          <= 1'b0;
      str_q          <= 1'b0;
      addr_q         <= '0;
      dsc_q          <= '0;
      cmplt_num_q    <= '0;
      cmplt_err_q    <= 1'b0;
      cmplt_to_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      protocol_err_q <= (dispatch_valid_i && state_q != IDLE) || (protocol_err_q && !err_clr_i);
      case (state_q)
        IDLE: if (dispatch_valid_i) begin
          num_q   <= dispatch_num_i;
          ext_q   <= dispatch_ext_i;
          str_q   <= dispatch_str_i;
          addr_q  <= dispatch_addr_i;
          dsc_q   <= dispatch_dscrptr_i;
          state_q <= REQ;
        end
        REQ: if (xfer_ack_i) begin
          cnt_q <= '0;
          if (xfer_done_i) begin
            state_q     <= CMPLT;
            cmplt_num_q <= num_q;
            cmplt_err_q <= xfer_err_i;
            cmplt_to_q  <= 1'b0;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 16'd1;
          if (xfer_done_i || expire) begin
            state_q     <= CMPLT;
            cmplt_num_q <= num_q;
            cmplt_err_q <= xfer_done_i ? xfer_err_i : 1'b1;
            cmplt_to_q  <= !xfer_done_i;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_dscrptr_dispatch_rsp.sv
// tb_dma_dscrptr_dispatch_rsp: transaction-level random checks of the dispatch responder.
module tb_dma_dscrptr_dispatch_rsp;
  localparam int W  = 2;
  localparam int DW = 133;
  localparam int T  = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dv = 1'b0, dext = 1'b0, dstr = 1'b0, ack = 1'b0, done = 1'b0, xerr = 1'b0, clr = 1'b0;
  logic [W-1:0] dnum = '0;
  logic [31:0] daddr = '0;
  logic [DW-1:0] ddsc = '0;
  logic ddone, req, xext, xstr, abort, cvalid, cerr, cto, perr;
  logic [W-1:0] xnum, cnum;
  logic [31:0] xaddr;
  logic [DW-1:0] xdsc;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dma_dscrptr_dispatch_rsp #(.NUM_INT_BDS(4), .NUM_INT_BDS_WIDTH(W), .DSCRPTR_WIDTH(DW), .TIMEOUT(T)) dut (
    .clock_i(clk), .resetn_i(rst_n),
    .dispatch_valid_i(dv), .dispatch_num_i(dnum), .dispatch_ext_i(dext), .dispatch_str_i(dstr),
    .dispatch_addr_i(daddr), .dispatch_dscrptr_i(ddsc), .dispatch_done_o(ddone),
    .xfer_req_o(req), .xfer_num_o(xnum), .xfer_ext_o(xext), .xfer_str_o(xstr),
    .xfer_addr_o(xaddr), .xfer_dscrptr_o(xdsc),
    .xfer_ack_i(ack), .xfer_done_i(done), .xfer_err_i(xerr), .xfer_abort_o(abort),
    .cmplt_valid_o(cvalid), .cmplt_num_o(cnum), .cmplt_err_o(cerr), .cmplt_timeout_o(cto),
    .protocol_err_o(perr), .err_clr_i(clr)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] all_outs();
    return 256'({req, xnum, xext, xstr, xaddr, xdsc, ddone, abort, cvalid, cnum, cerr, cto, perr});
  endfunction
  // ack_dly: cycles of req before ack; dd: cycles from ack to done (dd > T means the engine never answers)
  task automatic run_txn(input logic [W-1:0] num, input logic ext, input logic str, input logic [31:0] addr,
                         input logic [DW-1:0] dsc, input int ack_dly, input int dd, input logic err,
                         input logic extra, input logic clr_same);
    int m = 1 + ack_dly;
    int fin = m + T + 6;
    bit exp_abort = dd > T;
    int exp_done_c = exp_abort ? m + T + 1 : m + dd + 1;
    int req_n = 0, done_n = 0, done_c = -1, abort_n = 0, abort_c = -1, fld_bad = 0, vld_bad = 0;
    logic [W-1:0] c_num = '0;
    logic c_err = 1'b0, c_to = 1'b0;
    for (int c = 0; c <= fin; c++) begin
      @(posedge clk);
      #1;
      dv = (c == 0) || (extra && c == 2);
      dnum = (c == 0) ? num : ~num;
      dext = (c == 0) ? ext : ~ext;
      dstr = (c == 0) ? str : ~str;
      daddr = (c == 0) ? addr : ~addr;
      ddsc = (c == 0) ? dsc : ~dsc;
      ack = (c == m) || (c == m + T + 3);
      done = (!exp_abort && c == m + dd) || (c == m + T + 3);
      xerr = err;
      clr = (c == 0) || (clr_same && c == 2);
      @(negedge clk);
      if (req) req_n++;
      if (req && {xnum, xext, xstr, xaddr, xdsc} !== {num, ext, str, addr, dsc}) fld_bad++;
      if (ddone !== cvalid) vld_bad++;
      if (ddone) begin
        done_n++;
        done_c = c;
        c_num = cnum;
        c_err = cerr;
        c_to = cto;
      end
      if (abort) begin
        abort_n++;
        abort_c = c;
      end
      if (c == 1) chk("perr_cleared", 256'(perr), 256'(0));
    end
    dv = 1'b0;
    chk("req_cycles", 256'(req_n), 256'(ack_dly + 1));
    chk("xfer_fields", 256'(fld_bad), 256'(0));
    chk("done_eq_valid", 256'(vld_bad), 256'(0));
    chk("done_count", 256'(done_n), 256'(1));
    chk("done_cycle", 256'(done_c), 256'(exp_done_c));
    chk("abort_count", 256'(abort_n), 256'(exp_abort ? 1 : 0));
    chk("abort_cycle", 256'(abort_c), 256'(exp_abort ? m + T : -1));
    chk("cmplt_num", 256'(c_num), 256'(num));
    chk("cmplt_err", 256'(c_err), 256'(exp_abort ? 1'b1 : err));
    chk("cmplt_timeout", 256'(c_to), 256'(exp_abort));
    chk("cmplt_hold", 256'({cnum, cerr, cto}), 256'({num, exp_abort ? 1'b1 : err, exp_abort}));
    chk("protocol_err", 256'(perr), 256'(extra));
  endtask
  function automatic logic [DW-1:0] rnd_dsc();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", all_outs(), '0);
    rst_n = 1'b1;
    run_txn(2'd2, 1'b0, 1'b0, 32'h0, rnd_dsc(), 3, 10, 1'b0, 1'b0, 1'b0);
    run_txn(2'd1, 1'b1, 1'b1, 32'h8000_1000, rnd_dsc(), 2, 0, 1'b1, 1'b0, 1'b0);
    run_txn(2'd3, 1'b0, 1'b0, 32'h0, rnd_dsc(), 1, T + 5, 1'b0, 1'b0, 1'b0);
    run_txn(2'd0, 1'b1, 1'b0, 32'h1234_5678, rnd_dsc(), 0, T, 1'b0, 1'b0, 1'b0);
    run_txn(2'd1, 1'b0, 1'b0, 32'h0, rnd_dsc(), 0, 5, 1'b0, 1'b1, 1'b1);
    run_txn(2'd2, 1'b0, 1'b0, 32'h0, rnd_dsc(), 4, 2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      logic e = 1'($urandom);
      run_txn(W'($urandom), e, 1'($urandom), e ? $urandom : 32'h0, rnd_dsc(), $urandom_range(0, 5),
              $urandom_range(0, T + 3), 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
    end
    // Reset mid-transfer: outputs drop asynchronously and no done is issued for the lost descriptor.
    run_txn(2'd3, 1'b1, 1'b1, 32'hdead_beef, rnd_dsc(), 0, T + 2, 1'b0, 1'b1, 1'b0);
    begin
      int lost_done = 0;
      @(posedge clk);
      #1;
      dv = 1'b1;
      dnum = 2'd1;
      daddr = 32'hcafe_0000;
      ddsc = rnd_dsc();
      @(posedge clk);
      #1;
      dv = 1'b0;
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", all_outs(), '0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (ddone) lost_done++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < T + 4; c++) begin
        @(negedge clk);
        if (ddone) lost_done++;
      end
      chk("no_lost_done", 256'(lost_done), 256'(0));
    end
    run_txn(2'd2, 1'b0, 1'b0, 32'h0, rnd_dsc(), 1, 3, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
